// File: rtl/nios2_gen2_cpu_ocimem_arbiter_if.sv
// CPU-side Avalon debug-slave bus between the debug-slave wrapper and the
// OCI RAM arbiter. The master modport is the CPU side; the slave modport is
// the arbiter.
interface nios2_gen2_cpu_ocimem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] avalon_address;
  logic              avalon_read;
  logic              avalon_write;
  logic [DATA_W-1:0] avalon_writedata;
  logic [DATA_W-1:0] avalon_readdata;
  logic              avalon_waitrequest;

  modport master (
    output avalon_address, avalon_read, avalon_write, avalon_writedata,
    input  avalon_readdata, avalon_waitrequest
  );

  modport slave (
    input  avalon_address, avalon_read, avalon_write, avalon_writedata,
    output avalon_readdata, avalon_waitrequest
  );
endinterface

// File: rtl/nios2_gen2_cpu_ocimem_arbiter.sv
// OCI RAM arbiter: sequences JTAG monitor commands (one pending slot) and
// CPU Avalon debug-slave accesses onto the single-port OCI RAM, and owns the
// monitor address/data registers MonAReg/MonDReg.
// Build option: OCIMEM_JTAG_PRIORITY_EN selects fixed JTAG priority; when it
// is not defined the two requesters are served round-robin.
module nios2_gen2_cpu_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  nios2_gen2_cpu_ocimem_arbiter_if.slave avalon,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] MonAReg,
  output logic [DATA_W-1:0] MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT_J = 3'd1,
    S_CAP_J   = 3'd2,
    S_GRANT_C = 3'd3,
    S_CAP_C   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_slot_vld;
  logic              r_slot_wr;
  logic [DATA_W-1:0] r_slot_data;
  logic [ADDR_W-1:0] r_mona;
  logic [DATA_W-1:0] r_mond;
  logic              r_overrun;
  logic [DATA_W-1:0] r_readdata;

  logic w_cpu_req, w_cpu_wr, w_pick_j;
  logic w_addr_load, w_a_cmd, w_a_drop, w_b_drop, w_a_accept, w_b_accept;
  logic w_j_wr_done, w_j_rd_done, w_j_done;
  logic w_unused;

  // jdo bits outside the address/data/command fields carry no meaning here
  assign w_unused = ^{jdo[37:36], jdo[2:0]};

  // A simultaneous read and write from the CPU is served as a write
  assign w_cpu_req   = avalon.avalon_read | avalon.avalon_write;
  assign w_cpu_wr    = avalon.avalon_write;

  assign w_addr_load = take_action_ocimem_a & jdo[25];
  assign w_a_cmd     = take_action_ocimem_a & jdo[35];
  // _b loses to any _a in the same cycle; either loses to an occupied slot
  assign w_a_drop    = w_a_cmd & r_slot_vld;
  assign w_b_drop    = take_action_ocimem_b & (r_slot_vld | take_action_ocimem_a);
  assign w_a_accept  = w_a_cmd & ~r_slot_vld;
  assign w_b_accept  = take_action_ocimem_b & ~r_slot_vld & ~take_action_ocimem_a;

  assign w_j_wr_done = (r_state == S_GRANT_J) & r_slot_wr;
  assign w_j_rd_done = (r_state == S_CAP_J);
  assign w_j_done    = w_j_wr_done | w_j_rd_done;

`ifdef OCIMEM_JTAG_PRIORITY_EN
  // Fixed priority: a pending JTAG command always wins in IDLE
  assign w_pick_j = r_slot_vld;
`else
  logic r_rr_cpu;  // 1: CPU favoured on the next contention

  // Round-robin pointer points away from whoever was just granted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_cpu <= 1'b0;
    end else if ((r_state == S_IDLE) && (w_next == S_GRANT_J)) begin
      r_rr_cpu <= 1'b1;
    end else if ((r_state == S_IDLE) && (w_next == S_GRANT_C)) begin
      r_rr_cpu <= 1'b0;
    end else begin
      r_rr_cpu <= r_rr_cpu;
    end
  end

  assign w_pick_j = r_slot_vld & (~w_cpu_req | ~r_rr_cpu);
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (w_pick_j)       w_next = S_GRANT_J;
        else if (w_cpu_req) w_next = S_GRANT_C;
        else                w_next = S_IDLE;
      end
      S_GRANT_J: begin
        if (r_slot_wr) w_next = S_IDLE;
        else           w_next = S_CAP_J;
      end
      S_CAP_J:   w_next = S_IDLE;
      S_GRANT_C: begin
        if (w_cpu_wr) w_next = S_IDLE;
        else          w_next = S_CAP_C;
      end
      S_CAP_C:   w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // RAM port and Avalon response, combinational from state and registers
  always_comb begin
    ram_addr                  = '0;
    ram_rd                    = 1'b0;
    ram_wr                    = 1'b0;
    ram_wdata                 = '0;
    avalon.avalon_waitrequest = 1'b1;
    avalon.avalon_readdata    = r_readdata;
    case (r_state)
      S_GRANT_J: begin
        ram_addr = r_mona;
        if (r_slot_wr) begin
          ram_wr    = 1'b1;
          ram_wdata = r_slot_data;
        end else begin
          ram_rd    = 1'b1;
        end
      end
      S_GRANT_C: begin
        ram_addr = avalon.avalon_address;
        if (w_cpu_wr) begin
          ram_wr                    = 1'b1;
          ram_wdata                 = avalon.avalon_writedata;
          avalon.avalon_waitrequest = 1'b0;
        end else begin
          ram_rd                    = 1'b1;
        end
      end
      S_CAP_C: begin
        avalon.avalon_waitrequest = 1'b0;
        avalon.avalon_readdata    = ram_rdata;
      end
      default: begin
        ram_addr = '0;
      end
    endcase
  end

  // Pending JTAG slot: filled by an accepted strobe, freed on completion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot_vld  <= 1'b0;
      r_slot_wr   <= 1'b0;
      r_slot_data <= '0;
    end else if (w_a_accept) begin
      r_slot_vld  <= 1'b1;
      r_slot_wr   <= 1'b0;
    end else if (w_b_accept) begin
      r_slot_vld  <= 1'b1;
      r_slot_wr   <= 1'b1;
      r_slot_data <= jdo[34:3];
    end else if (w_j_done) begin
      r_slot_vld  <= 1'b0;
    end else begin
      r_slot_vld  <= r_slot_vld;
    end
  end

  // Monitor address: JTAG load wins, otherwise post-increment on completion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mona <= '0;
    end else if (w_addr_load) begin
      r_mona <= jdo[26+ADDR_W-1:26];
    end else if (w_j_done) begin
      r_mona <= r_mona + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      r_mona <= r_mona;
    end
  end

  // Monitor data: read data or the written word on JTAG completion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mond <= '0;
    end else if (w_j_wr_done) begin
      r_mond <= r_slot_data;
    end else if (w_j_rd_done) begin
      r_mond <= ram_rdata;
    end else begin
      r_mond <= r_mond;
    end
  end

  // Sticky overrun flag: a drop sets it even if an address load clears it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (w_a_drop | w_b_drop) begin
      r_overrun <= 1'b1;
    end else if (w_addr_load) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  // Held copy of the last CPU read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else if (r_state == S_CAP_C) begin
      r_readdata <= ram_rdata;
    end else begin
      r_readdata <= r_readdata;
    end
  end

  assign MonAReg      = r_mona;
  assign MonDReg      = r_mond;
  assign jtag_overrun = r_overrun;
  assign jtag_busy    = r_slot_vld | (r_state == S_GRANT_J) | (r_state == S_CAP_J);

endmodule

// File: tb/tb_nios2_gen2_cpu_ocimem_arbiter.sv
// Directed, table-driven bench for the OCI RAM arbiter (default round-robin
// build) with a behavioural single-port RAM of one-cycle read latency.
module tb_nios2_gen2_cpu_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        ta_a, ta_b;
  logic [7:0]  ram_addr;
  logic        ram_rd, ram_wr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;
  logic [7:0]  mona;
  logic [31:0] mond;
  logic        busy, ovr;
  logic [31:0] mem [0:255];

  int n_vec = 0;
  int n_err = 0;

  nios2_gen2_cpu_ocimem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) av_if ();

  nios2_gen2_cpu_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .jdo                  (jdo),
    .take_action_ocimem_a (ta_a),
    .take_action_ocimem_b (ta_b),
    .avalon               (av_if),
    .ram_addr             (ram_addr),
    .ram_rd               (ram_rd),
    .ram_wr               (ram_wr),
    .ram_wdata            (ram_wdata),
    .ram_rdata            (ram_rdata),
    .MonAReg              (mona),
    .MonDReg              (mond),
    .jtag_busy            (busy),
    .jtag_overrun         (ovr)
  );

  always #5 clk = ~clk;

  // behavioural OCI RAM
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_wdata;
    if (ram_rd) ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic        a, b;
    logic [37:0] jdo;
    logic        ar, aw;
    logic [7:0]  aaddr;
    logic [31:0] awd;
    logic        e_wait, e_rd, e_wr;
    logic [7:0]  e_addr;
    logic [31:0] e_wdata;
    logic [7:0]  e_mona;
    logic [31:0] e_mond;
    logic        e_busy, e_ovr;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vt[$];

  function automatic logic [37:0] ja(input logic ld, input logic [7:0] ad, input logic rd);
    ja = {2'b00, rd, 1'b0, ad, ld, 25'd0};
  endfunction

  function automatic logic [37:0] jb(input logic [31:0] d);
    jb = {3'b000, d, 3'b000};
  endfunction

  task automatic add(input logic a, b, input logic [37:0] j, input logic ar, aw,
                     input logic [7:0] aad, input logic [31:0] awd,
                     input logic ew, er, ewr, input logic [7:0] ead, input logic [31:0] ewd,
                     input logic [7:0] ema, input logic [31:0] emd,
                     input logic eb, eo, input logic [31:0] erd);
    vec_t v;
    v.a = a; v.b = b; v.jdo = j; v.ar = ar; v.aw = aw; v.aaddr = aad; v.awd = awd;
    v.e_wait = ew; v.e_rd = er; v.e_wr = ewr; v.e_addr = ead; v.e_wdata = ewd;
    v.e_mona = ema; v.e_mond = emd; v.e_busy = eb; v.e_ovr = eo; v.e_rdata = erd;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic a, b, input logic [37:0] j, input logic ar, aw,
                       input logic [7:0] aad, input logic [31:0] awd);
    ta_a = a; ta_b = b; jdo = j;
    av_if.avalon_read = ar; av_if.avalon_write = aw;
    av_if.avalon_address = aad; av_if.avalon_writedata = awd;
  endtask

  localparam logic [31:0] D  = 32'hDEADBEEF;
  localparam logic [31:0] R  = 32'hA5A5A5A5;
  localparam logic [31:0] M1 = 32'h12345678;
  localparam logic [31:0] B  = 32'h0BADF00D;
  localparam logic [31:0] Q0 = 32'h11110000;
  localparam logic [31:0] C1 = 32'hCAFEF00D;
  localparam logic [31:0] Q2 = 32'h22222222;
  localparam logic [31:0] Q3 = 32'h33333333;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = D;  mem[8'h05] = R;  mem[8'h00] = Q0;
    mem[8'h02] = Q2; mem[8'h03] = Q3;

    //  a b jdo                ar aw addr   wdata     | wait rd wr addr   wdata    mona   mond busy ovr rdata
    // reset state
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h00,32'h0,0,0,32'h0);
    // address load + JTAG read at 0x10
    add(1,0,ja(1,8'h10,1),     0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h00,32'h0,0,0,32'h0);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h10,32'h0,1,0,32'h0);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,1,0,8'h10,32'h0, 8'h10,32'h0,1,0,32'h0);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h10,32'h0,1,0,32'h0);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h11,D,0,0,32'h0);
    // load 0xFF then JTAG write with address wrap
    add(1,0,ja(1,8'hFF,0),     0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h11,D,0,0,32'h0);
    add(0,1,jb(M1),            0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'hFF,D,0,0,32'h0);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'hFF,D,1,0,32'h0);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,0,1,8'hFF,M1,    8'hFF,D,1,0,32'h0);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h00,M1,0,0,32'h0);
    // CPU read at 0x05: waitrequest 1,1,0
    add(0,0,38'd0,             1,0,8'h05,32'h0,  1,0,0,8'h00,32'h0, 8'h00,M1,0,0,32'h0);
    add(0,0,38'd0,             1,0,8'h05,32'h0,  1,1,0,8'h05,32'h0, 8'h00,M1,0,0,32'h0);
    add(0,0,38'd0,             1,0,8'h05,32'h0,  0,0,0,8'h00,32'h0, 8'h00,M1,0,0,R);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h00,M1,0,0,R);
    // CPU write at 0x30 (2nd cycle) then read back
    add(0,0,38'd0,             0,1,8'h30,B,      1,0,0,8'h00,32'h0, 8'h00,M1,0,0,R);
    add(0,0,38'd0,             0,1,8'h30,B,      0,0,1,8'h30,B,     8'h00,M1,0,0,R);
    add(0,0,38'd0,             1,0,8'h30,32'h0,  1,0,0,8'h00,32'h0, 8'h00,M1,0,0,R);
    add(0,0,38'd0,             1,0,8'h30,32'h0,  1,1,0,8'h30,32'h0, 8'h00,M1,0,0,R);
    add(0,0,38'd0,             1,0,8'h30,32'h0,  0,0,0,8'h00,32'h0, 8'h00,M1,0,0,B);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h00,M1,0,0,B);
    // contention, pointer favours JTAG: JTAG first, then CPU
    add(1,0,ja(0,8'h00,1),     0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h00,M1,0,0,B);
    add(0,0,38'd0,             1,0,8'h05,32'h0,  1,0,0,8'h00,32'h0, 8'h00,M1,1,0,B);
    add(0,0,38'd0,             1,0,8'h05,32'h0,  1,1,0,8'h00,32'h0, 8'h00,M1,1,0,B);
    add(0,0,38'd0,             1,0,8'h05,32'h0,  1,0,0,8'h00,32'h0, 8'h00,M1,1,0,B);
    add(0,0,38'd0,             1,0,8'h05,32'h0,  1,0,0,8'h00,32'h0, 8'h01,Q0,0,0,B);
    add(0,0,38'd0,             1,0,8'h05,32'h0,  1,1,0,8'h05,32'h0, 8'h01,Q0,0,0,B);
    add(0,0,38'd0,             1,0,8'h05,32'h0,  0,0,0,8'h00,32'h0, 8'h01,Q0,0,0,R);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h01,Q0,0,0,R);
    // lone JTAG write moves the pointer to the CPU side
    add(0,1,jb(C1),            0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h01,Q0,0,0,R);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h01,Q0,1,0,R);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,0,1,8'h01,C1,    8'h01,Q0,1,0,R);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h02,C1,0,0,R);
    // contention, pointer favours CPU: CPU first, then JTAG
    add(1,0,ja(0,8'h00,1),     0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h02,C1,0,0,R);
    add(0,0,38'd0,             1,0,8'h05,32'h0,  1,0,0,8'h00,32'h0, 8'h02,C1,1,0,R);
    add(0,0,38'd0,             1,0,8'h05,32'h0,  1,1,0,8'h05,32'h0, 8'h02,C1,1,0,R);
    add(0,0,38'd0,             1,0,8'h05,32'h0,  0,0,0,8'h00,32'h0, 8'h02,C1,1,0,R);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h02,C1,1,0,R);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,1,0,8'h02,32'h0, 8'h02,C1,1,0,R);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h02,C1,1,0,R);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h03,Q2,0,0,R);
    // overrun: _b while read pending is dropped; address load clears flag
    add(1,0,ja(0,8'h00,1),     0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h03,Q2,0,0,R);
    add(0,1,jb(32'h55AA55AA),  0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h03,Q2,1,0,R);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,1,0,8'h03,32'h0, 8'h03,Q2,1,1,R);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h03,Q2,1,1,R);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h04,Q3,0,1,R);
    add(1,0,ja(1,8'h40,0),     0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h04,Q3,0,1,R);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h40,Q3,0,0,R);
    // _a and _b together: load applies, _b dropped, overrun set
    add(1,1,ja(1,8'h50,0),     0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h40,Q3,0,0,R);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h50,Q3,0,1,R);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h50,Q3,0,1,R);
    add(1,0,ja(1,8'h50,0),     0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h50,Q3,0,1,R);
    add(0,0,38'd0,             0,0,8'h00,32'h0,  1,0,0,8'h00,32'h0, 8'h50,Q3,0,0,R);

    // reset
    reset_n = 1'b0;
    drive(0, 0, 38'd0, 0, 0, 8'h00, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // table loop: apply on falling edge, compare 2 time units later
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drive(vt[i].a, vt[i].b, vt[i].jdo, vt[i].ar, vt[i].aw, vt[i].aaddr, vt[i].awd);
      #2;
      chk($sformatf("v%0d waitreq", i), {31'd0, av_if.avalon_waitrequest}, {31'd0, vt[i].e_wait});
      chk($sformatf("v%0d ram_rd", i),  {31'd0, ram_rd},   {31'd0, vt[i].e_rd});
      chk($sformatf("v%0d ram_wr", i),  {31'd0, ram_wr},   {31'd0, vt[i].e_wr});
      chk($sformatf("v%0d ram_addr", i), {24'd0, ram_addr}, {24'd0, vt[i].e_addr});
      chk($sformatf("v%0d ram_wdata", i), ram_wdata, vt[i].e_wdata);
      chk($sformatf("v%0d MonAReg", i), {24'd0, mona}, {24'd0, vt[i].e_mona});
      chk($sformatf("v%0d MonDReg", i), mond, vt[i].e_mond);
      chk($sformatf("v%0d busy", i),    {31'd0, busy}, {31'd0, vt[i].e_busy});
      chk($sformatf("v%0d overrun", i), {31'd0, ovr},  {31'd0, vt[i].e_ovr});
      chk($sformatf("v%0d readdata", i), av_if.avalon_readdata, vt[i].e_rdata);
    end

    // reset asserted in CAP_C with a JTAG read queued
    @(negedge clk);
    drive(0, 0, 38'd0, 1, 0, 8'h05, 32'h0);
    @(negedge clk);
    drive(1, 0, ja(0, 8'h00, 1), 1, 0, 8'h05, 32'h0);
    #2 chk("rst grant_c ram_rd", {31'd0, ram_rd}, 32'd1);
    @(negedge clk);
    drive(0, 0, 38'd0, 1, 0, 8'h05, 32'h0);
    #1 chk("rst cap_c waitreq", {31'd0, av_if.avalon_waitrequest}, 32'd0);
    chk("rst cap_c busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst waitreq",   {31'd0, av_if.avalon_waitrequest}, 32'd1);
    chk("rst readdata",  av_if.avalon_readdata, 32'h0);
    chk("rst ram_rd",    {31'd0, ram_rd}, 32'd0);
    chk("rst ram_wr",    {31'd0, ram_wr}, 32'd0);
    chk("rst ram_addr",  {24'd0, ram_addr}, 32'd0);
    chk("rst ram_wdata", ram_wdata, 32'h0);
    chk("rst MonAReg",   {24'd0, mona}, 32'd0);
    chk("rst MonDReg",   mond, 32'h0);
    chk("rst busy",      {31'd0, busy}, 32'd0);
    chk("rst overrun",   {31'd0, ovr}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 0, 38'd0, 0, 0, 8'h00, 32'h0);
    // queued command must have been discarded
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #2;
      chk($sformatf("post-rst%0d ram_rd", k), {31'd0, ram_rd}, 32'd0);
      chk($sformatf("post-rst%0d busy", k),   {31'd0, busy}, 32'd0);
      chk($sformatf("post-rst%0d MonDReg", k), mond, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
